rom_fetch_ctrl: RTL and testbench
=================================

ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 rom_addr  output  32  byte address to the instruction ROM; equals the internal fetch_pc register.
REQ-006 rom_data  input  32  ROM read data; combinational from rom_addr in the same cycle.
REQ-007 redirect_valid  input  1  core branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 instr_valid  output  1  buffer head holds a valid instruction.
REQ-010 instr_ready  input  1  core accepts the head this cycle.
REQ-011 instr_pc  output  32  address of the head instruction.
REQ-012 instr_data  output  32  head instruction word.
REQ-013 fetch_err  output  1  out-of-range fetch flag; see Configuration.

Function
REQ-014 Buffer SHALL be a DEPTH-entry FIFO of {pc, data} pairs with an occupancy count from 0 to DEPTH.
REQ-015 instr_valid SHALL equal (count != 0); instr_pc/instr_data SHALL show the head entry, and SHALL be zero when count == 0.
REQ-016 Dequeue SHALL occur on an edge where instr_valid && instr_ready.
REQ-017 Enqueue SHALL occur on an edge where state == FETCH, redirect_valid == 0, and (count < DEPTH or a dequeue happens on the same edge); it captures {fetch_pc, rom_data} and sets fetch_pc to fetch_pc + 4.
REQ-018 Simultaneous enqueue and dequeue at full SHALL leave count at DEPTH with no data loss.
REQ-019 fetch_pc SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-020 When redirect_valid is high on an edge, the FIFO SHALL be flushed (count = 0) and fetch_pc SHALL be loaded with {redirect_pc[31:2], 2'b00}; no enqueue or dequeue SHALL occur on that edge, even if instr_ready is high.
REQ-021 Redirect-to-valid latency SHALL be 2 edges: flush on edge N, target enqueued on edge N+1, instr_valid high after edge N+1.
REQ-022 Back-to-back redirects SHALL each flush; only the last target is fetched.
REQ-023 FSM states SHALL be FETCH and ERR. FETCH -> ERR on a bounds violation (Configuration); ERR -> FETCH on redirect_valid; ERR performs no enqueue, but dequeue of buffered entries continues.
REQ-024 The block SHALL have zero combinational paths from instr_ready or redirect_valid to rom_addr.

Reset
REQ-025 While rst is high: fetch_pc = RESET_PC, count = 0, FIFO pointers = 0, state = FETCH, fetch_err = 0, instr_valid = 0.
REQ-026 Assertion of rst mid-operation SHALL immediately discard all buffered entries and any pending redirect.
REQ-027 The first enqueue SHALL occur on the first rising edge after rst deasserts; instr_valid is high after that edge with instr_pc = RESET_PC.

Configuration
REQ-028 Macro ROM_FETCH_BOUNDS_CHECK_EN defined: a fetch_pc with bits [31:12] nonzero (outside the 1024-word ROM) SHALL block enqueue, move the FSM to ERR, and set fetch_err high from the next edge; fetch_err stays set until redirect or reset.
REQ-029 Macro not defined: there is no bounds check, fetch_err is tied to 0, the ERR state is unreachable, and the ROM aliases by address bits [11:2].

Verification
REQ-030 Reset release, RESET_PC = 0, instr_ready = 1 held -> instr_pc sequence 0x0, 0x4, 0x8, ... on consecutive cycles, with instr_data matching ROM words 0, 1, 2.
REQ-031 instr_ready = 0 for 10 cycles after reset -> count saturates at DEPTH (2), instr_pc holds 0x0, rom_addr holds 0x8; then instr_ready = 1 -> 0x0, 0x4, 0x8 are delivered with no gap and no duplicate.
REQ-032 redirect_valid pulse with redirect_pc = 0x103 while the buffer is full and instr_ready = 1 -> no dequeue on that edge, instr_valid = 0 for one cycle, then instr_pc = 0x100, followed by 0x104.
REQ-033 Two consecutive redirect cycles to 0x40 then 0x80 -> no instr_pc = 0x40 ever presented; the first valid instr_pc = 0x80.
REQ-034 With ROM_FETCH_BOUNDS_CHECK_EN defined, redirect to 0xFFC, instr_ready = 1 -> 0xFFC is delivered, fetch_err rises, no 0x1000 entry appears, and a redirect to 0x0 clears fetch_err and resumes fetch.
REQ-035 rst asserted asynchronously mid-stream with count = 2 -> instr_valid drops before the next edge; after release, instr_pc = RESET_PC.

Source files
------------

// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch controller: streams sequential ROM words into a DEPTH-entry prefetch FIFO with redirect flush.
// Optional macro ROM_FETCH_BOUNDS_CHECK_EN enables the 4 KiB fetch-window bounds check and the ERR state.
module rom_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_data,
  output logic        fetch_err
);
  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [0:0] {FETCH = 1'b0, ERR = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic [CW-1:0] count_r, count_s;
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic          fetch_err_r, fetch_err_s;
  logic          deq_s, enq_s, in_bounds_s;

`ifdef ROM_FETCH_BOUNDS_CHECK_EN
  assign in_bounds_s = (fetch_pc_r[31:12] == 20'h0_0000);
  assign fetch_err   = fetch_err_r;
`else
  assign in_bounds_s = 1'b1;
  assign fetch_err   = 1'b0;
`endif

  assign rom_addr    = fetch_pc_r;
  assign instr_valid = (count_r != '0);
  assign instr_pc    = instr_valid ? pc_mem_r[rd_ptr_r]   : 32'h0000_0000;
  assign instr_data  = instr_valid ? data_mem_r[rd_ptr_r] : 32'h0000_0000;

  // Next-state, enqueue/dequeue decisions and occupancy update; redirect overrides everything.
  always_comb begin
    state_s     = state_r;
    fetch_pc_s  = fetch_pc_r;
    count_s     = count_r;
    fetch_err_s = fetch_err_r;
    deq_s       = 1'b0;
    enq_s       = 1'b0;
    if (redirect_valid) begin
      state_s     = FETCH;
      fetch_pc_s  = {redirect_pc[31:2], 2'b00};
      count_s     = '0;
      fetch_err_s = 1'b0;
    end else begin
      deq_s = instr_valid && instr_ready;
      case (state_r)
        FETCH: begin
          if (!in_bounds_s) begin
            state_s     = ERR;
            fetch_err_s = 1'b1;
          end else if ((count_r != FULL) || deq_s) begin
            enq_s      = 1'b1;
            fetch_pc_s = fetch_pc_r + 32'd4;
          end else begin
            enq_s = 1'b0;
          end
        end
        ERR:     enq_s = 1'b0;
        default: state_s = FETCH;
      endcase
      if (enq_s && !deq_s) begin
        count_s = count_r + CW'(1);
      end else if (!enq_s && deq_s) begin
        count_s = count_r - CW'(1);
      end else begin
        count_s = count_r;
      end
    end
  end

  // Control state: FSM, fetch address, occupancy and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FETCH;
      fetch_pc_r  <= RESET_PC;
      count_r     <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      fetch_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      count_r     <= count_s;
      fetch_err_r <= fetch_err_s;
      if (redirect_valid) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (enq_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (deq_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // FIFO payload storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
      data_mem_r[wr_ptr_r] <= rom_data;
    end
  end
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_rom_fetch_ctrl;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr, rom_data, redirect_pc, instr_pc, instr_data;
  logic        redirect_valid, instr_valid, instr_ready, fetch_err;

  logic [31:0] rom_mem [1024];
  int checks = 0;
  int passes = 0;

  rom_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_pc(instr_pc), .instr_data(instr_data), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  assign rom_data = rom_mem[rom_addr[11:2]];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return rom_mem[a[11:2]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a queue of fetched {pc,data} plus the next fetch address and an error flag.
  typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_err;

  function automatic void model_reset();
    mq.delete();
    m_pc  = RESET_PC;
    m_err = 1'b0;
  endfunction

  function automatic void model_edge(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit deq, enq, inb;
    entry_t e;
    if (redir) begin
      mq.delete();
      m_pc  = {rpc[31:2], 2'b00};
      m_err = 1'b0;
      return;
    end
`ifdef ROM_FETCH_BOUNDS_CHECK_EN
    inb = (m_pc < 32'h0000_1000);
`else
    inb = 1'b1;
`endif
    deq = (mq.size() > 0) && rdy;
    enq = !m_err && inb && ((mq.size() < DEPTH) || deq);
    if (!m_err && !inb) m_err = 1'b1;
    if (deq) void'(mq.pop_front());
    if (enq) begin
      e.pc   = m_pc;
      e.data = rom_word(m_pc);
      mq.push_back(e);
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic model_check();
    logic [31:0] epc, edata;
    epc   = (mq.size() > 0) ? mq[0].pc   : 32'h0;
    edata = (mq.size() > 0) ? mq[0].data : 32'h0;
    check("rand_valid", {31'h0, instr_valid}, {31'h0, (mq.size() > 0)});
    check("rand_pc", instr_pc, epc);
    check("rand_data", instr_data, edata);
    check("rand_addr", rom_addr, m_pc);
    check("rand_err", {31'h0, fetch_err}, {31'h0, m_err});
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic cyc(input bit redir, input logic [31:0] rpc, input bit rdy);
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string name, input bit ev, input logic [31:0] epc,
                            input logic [31:0] eaddr);
    check({name, "_valid"}, {31'h0, instr_valid}, {31'h0, ev});
    check({name, "_pc"}, instr_pc, ev ? epc : 32'h0);
    check({name, "_data"}, instr_data, ev ? rom_word(epc) : 32'h0);
    check({name, "_addr"}, rom_addr, eaddr);
  endtask

  typedef struct {
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input bit r, input logic [31:0] rp, input bit rd,
                              input bit ev, input logic [31:0] epc, input logic [31:0] ea);
    vec_t v;
    v.redir = r; v.rpc = rp; v.rdy = rd; v.ev = ev; v.epc = epc; v.eaddr = ea;
    vq.push_back(v);
  endfunction

  initial begin
    bit          redir, rdy;
    logic [31:0] rpc;

    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;

    // Stall after reset, drain, redirect while full, back-to-back redirects.
    add(0, 32'h0, 0, 1, 32'h0, 32'h4);
    for (int i = 0; i < 9; i++) add(0, 32'h0, 0, 1, 32'h0, 32'h8);
    add(0, 32'h0,   1, 1, 32'h4,   32'hC);
    add(0, 32'h0,   1, 1, 32'h8,   32'h10);
    add(0, 32'h0,   1, 1, 32'hC,   32'h14);
    add(1, 32'h103, 1, 0, 32'h0,   32'h100);
    add(0, 32'h0,   1, 1, 32'h100, 32'h104);
    add(0, 32'h0,   1, 1, 32'h104, 32'h108);
    add(1, 32'h40,  1, 0, 32'h0,   32'h40);
    add(1, 32'h80,  1, 0, 32'h0,   32'h80);
    add(0, 32'h0,   1, 1, 32'h80,  32'h84);
    add(0, 32'h0,   1, 1, 32'h84,  32'h88);

    @(posedge clk); #1;
    check_head("reset", 1'b0, 32'h0, RESET_PC);
    check("reset_err", {31'h0, fetch_err}, 32'h0);
    @(negedge clk); rst = 1'b0;

    foreach (vq[i]) begin
      cyc(vq[i].redir, vq[i].rpc, vq[i].rdy);
      check_head($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].eaddr);
    end

    // Fill to two entries, then assert reset asynchronously between edges.
    cyc(0, 32'h0, 0);
    check_head("prefill", 1'b1, 32'h84, 32'h8C);
    #2 rst = 1'b1;
    #1;
    check_head("async_rst", 1'b0, 32'h0, RESET_PC);
    check("async_rst_err", {31'h0, fetch_err}, 32'h0);
    @(negedge clk); rst = 1'b0;
    cyc(0, 32'h0, 0);
    check_head("post_rst", 1'b1, RESET_PC, RESET_PC + 32'd4);

`ifndef ROM_FETCH_BOUNDS_CHECK_EN
    // Fetch address wraps from the top of the address space to zero.
    cyc(1, 32'hFFFF_FFFE, 0);
    check_head("wrap0", 1'b0, 32'h0, 32'hFFFF_FFFC);
    cyc(0, 32'h0, 0);
    check_head("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h0);
    cyc(0, 32'h0, 0);
    check_head("wrap2", 1'b1, 32'hFFFF_FFFC, 32'h4);
    cyc(0, 32'h0, 1);
    check_head("wrap3", 1'b1, 32'h0, 32'h8);
    check("wrap_err", {31'h0, fetch_err}, 32'h0);
`else
    // Last in-range word is delivered, then fetch stops with the error flag until redirect.
    cyc(1, 32'hFFC, 1);
    check_head("bnd0", 1'b0, 32'h0, 32'hFFC);
    cyc(0, 32'h0, 1);
    check_head("bnd1", 1'b1, 32'hFFC, 32'h1000);
    check("bnd1_err", {31'h0, fetch_err}, 32'h0);
    cyc(0, 32'h0, 1);
    check_head("bnd2", 1'b0, 32'h0, 32'h1000);
    check("bnd2_err", {31'h0, fetch_err}, 32'h1);
    cyc(0, 32'h0, 1);
    check_head("bnd3", 1'b0, 32'h0, 32'h1000);
    check("bnd3_err", {31'h0, fetch_err}, 32'h1);
    cyc(1, 32'h0, 1);
    check("bnd4_err", {31'h0, fetch_err}, 32'h0);
    cyc(0, 32'h0, 1);
    check_head("bnd5", 1'b1, 32'h0, 32'h4);
`endif

    // Randomized traffic against the reference model, starting from a fresh reset.
    rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    #1;
    model_reset();
    model_check();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h1FFF));
      rdy   = ($urandom_range(0, 2) != 0);
      cyc(redir, rpc, rdy);
      model_edge(redir, rpc, rdy);
      model_check();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
